// File: rtl/mult16_seq_ctrl.sv
// Radix-2 shift-add unsigned multiplier controller. It drives an external
// ripple adder and returns a 2*WIDTH-bit product through a start/done handshake.
module mult16_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int ADD_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               err,
  output logic [ADD_W-1:0]   add_a,
  output logic [ADD_W-1:0]   add_b,
  output logic               add_cin,
  input  logic [ADD_W-1:0]   add_s,
  input  logic               add_co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only on a clock edge where the FSM is in
  // IDLE. done is a single-cycle pulse; product is valid from that pulse until
  // the next one. busy is high for every cycle the FSM spends in RUN.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             add_bad;
  logic             last_iter;

  assign sum       = add_s[WIDTH:0];
  assign hi_nxt    = sum[WIDTH:1];
  assign lo_nxt    = {sum[0], lo[WIDTH-1:1]};
  assign last_iter = (count == LAST);

  // A correct adder never produces a carry-out or any bit above WIDTH here.
  assign add_bad = add_co || ((add_s >> (WIDTH + 1)) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_RUN: begin
        busy  = 1'b1;
        add_a = {{(ADD_W - WIDTH){1'b0}}, hi};
        if (lo[0]) begin
          add_b = {{(ADD_W - WIDTH){1'b0}}, mcand};
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            count <= '0;
          end
        end
        S_RUN: begin
          hi <= hi_nxt;
          lo <= lo_nxt;
          if (last_iter) begin
            count   <= '0;
            product <= {hi_nxt, lo_nxt};
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky until reset; the iteration still proceeds on the low sum bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S_RUN && add_bad) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed bench for mult16_seq_ctrl with a behavioural adder model that can
// inject a carry-out fault.
module tb_mult16_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int ADD_W = 24;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               err;
  logic [ADD_W-1:0]   add_a;
  logic [ADD_W-1:0]   add_b;
  logic               add_cin;
  logic [ADD_W-1:0]   add_s;
  logic               add_co;
  logic               add_co_raw;
  logic               force_co;

  int total;
  int bad;

  logic cin_seen;
  logic co_seen;
  logic addb_nz;

  mult16_seq_ctrl #(.WIDTH(WIDTH), .ADD_W(ADD_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .err     (err),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_s   (add_s),
    .add_co  (add_co)
  );

  // Adder model: ripple adder behaviour plus optional forced carry-out.
  assign {add_co_raw, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{ADD_W{1'b0}}, add_cin};
  assign add_co = add_co_raw | force_co;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: plain, mode 1: stray starts at t5 and during DONE,
  // mode 2: force carry-out on the 4th RUN cycle.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input int mode, output logic [31:0] prod,
                        output int nbusy, output int ndone,
                        output int done_at, output int err_at);
    prod     = 32'hDEAD_BEEF;
    nbusy    = 0;
    ndone    = 0;
    done_at  = -1;
    err_at   = -1;
    cin_seen = 1'b0;
    co_seen  = 1'b0;
    addb_nz  = 1'b0;
    do_start(ta, tb_v);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && add_cin) cin_seen = 1'b1;
      if (busy && add_co) co_seen = 1'b1;
      if (busy && add_b != '0) addb_nz = 1'b1;
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          prod    = product;
        end
      end
      if (err && err_at < 0) err_at = k;
      start    = 1'b0;
      force_co = 1'b0;
      if (mode == 1 && (k == 4 || done)) begin
        start = 1'b1;
        a     = 16'd1;
        b     = 16'd1;
      end
      if (mode == 2 && k == 3) force_co = 1'b1;
    end
    start    = 1'b0;
    force_co = 1'b0;
  endtask

  logic [31:0] prod;
  int nbusy, ndone, done_at, err_at;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    force_co = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_add_a", {8'd0, add_a}, 32'd0);
    chk("rst_add_b", {8'd0, add_b}, 32'd0);
    rst = 1'b0;

    run_op(16'd3, 16'd5, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t1_product", prod, 32'h0000_000F);
    chk("t1_busy_cycles", nbusy, 32'd16);
    chk("t1_done_cycles", ndone, 32'd1);
    chk("t1_done_at", done_at, 32'd16);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_cin", {31'd0, cin_seen}, 32'd0);
    chk("t1_idle_add_a", {8'd0, add_a}, 32'd0);
    chk("t1_held_product", product, 32'h0000_000F);

    run_op(16'hFFFF, 16'hFFFF, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t2_product", prod, 32'hFFFE_0001);
    chk("t2_co_seen", {31'd0, co_seen}, 32'd0);
    chk("t2_err", {31'd0, err}, 32'd0);

    run_op(16'h1234, 16'h0000, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t3a_product", prod, 32'd0);
    chk("t3a_add_b_zero", {31'd0, addb_nz}, 32'd0);
    chk("t3a_busy_cycles", nbusy, 32'd16);

    run_op(16'h0000, 16'hABCD, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t3b_product", prod, 32'd0);

    run_op(16'd7, 16'd9, 1, prod, nbusy, ndone, done_at, err_at);
    chk("t4_product", prod, 32'd63);
    chk("t4_done_cycles", ndone, 32'd1);
    chk("t4_busy_cycles", nbusy, 32'd16);
    chk("t4_done_at", done_at, 32'd16);
    chk("t4_held_product", product, 32'd63);

    do_start(16'd100, 16'd200);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_rst_product", product, 32'd0);
    chk("t5_rst_add_a", {8'd0, add_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("t5_no_done", ndone, 32'd0);
    chk("t5_no_busy", nbusy, 32'd0);
    run_op(16'd2, 16'd3, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t5_product", prod, 32'd6);

    run_op(16'd10, 16'd10, 2, prod, nbusy, ndone, done_at, err_at);
    chk("t6_err_at", err_at, 32'd4);
    chk("t6_product", prod, 32'd100);
    chk("t6_err_after", {31'd0, err}, 32'd1);

    run_op(16'd5, 16'd5, 0, prod, nbusy, ndone, done_at, err_at);
    chk("t6_next_product", prod, 32'd25);
    chk("t6_err_sticky", {31'd0, err}, 32'd1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_err_cleared", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult16_seq_ctrl.md
Name: mult16_seq_ctrl

Overview:
Sequential radix-2 shift-add 16x16 unsigned multiplier controller. It sits directly upstream of the 24-bit ripple adder (FA24bit) in the 16-bit multiplier datapath.
- Each iteration it drives the adder's operand and carry inputs, then consumes its sum and carry-out.
- It sequences 16 add/shift iterations and returns a 32-bit product with a start/done handshake.
- The adder is instantiated outside this block and connected through the add_* ports.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits.
ADD_W, 24, width of the external adder; must be >= WIDTH+1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  multiplicand; captured on accepted start.
b  input  WIDTH  multiplier; captured on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when product is valid.
product  output  2*WIDTH  result; held until the next DONE.
err  output  1  sticky adder-consistency error.
add_a  output  ADD_W  adder operand A.
add_b  output  ADD_W  adder operand B.
add_cin  output  1  adder carry-in; tied 0.
add_s  input  ADD_W  adder sum.
add_co  input  1  adder carry-out.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- On rst, immediately and regardless of clk: state=IDLE, busy=0, done=0, product=0, err=0, internal hi/lo/mcand/count=0.
- Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t0:
  - mcand<=a, lo<=b, hi<=0, count<=0.
  - state->RUN.
- IDLE, start=0: stay in IDLE.
- RUN, combinational adder drive:
  - add_a = zero-extended hi.
  - add_b = zero-extended mcand if lo[0]=1, else 0.
  - add_cin = 0.
- RUN, each edge:
  - Let sum = add_s[WIDTH:0].
  - hi<=sum[WIDTH:1]; lo<={sum[0], lo[WIDTH-1:1]}.
  - count<=count+1.
- RUN, at edge with count==WIDTH-1 (t16 for WIDTH=16):
  - Apply the final iteration.
  - product<={new hi, new lo}.
  - state->DONE.
- DONE: done=1 for exactly one cycle, busy=0. Next edge: state->IDLE unconditionally.
- Timing:
  - busy is high from t0 to t16.
  - done is high from t16 to t17, i.e. 16 cycles after the start edge.
  - Earliest next accepted start is the t17 edge.
- start while busy or in DONE is ignored. No queuing, operands are not recaptured, and in-flight a/b changes have no effect.
- In IDLE and DONE, add_a=add_b=0 and add_cin=0.
- err:
  - Set at any RUN edge where add_co=1 or add_s[ADD_W-1:WIDTH+1]!=0. Both are impossible with a correct adder, since max sum is 2^(WIDTH+1)-2.
  - Cleared only by rst. Computation continues and uses add_s[WIDTH:0] as-is.
- Arithmetic: unsigned only. No overflow is possible; 0xFFFF*0xFFFF fits in 32 bits.
- Boundaries:
  - b=0 gives 16 iterations of zero adds and product 0.
  - a=0 gives product 0.
  - count wraps to 0 on leaving RUN.

Test Plan:
- Reset, then start with a=3, b=5 at t0 -> busy t0..t16; done pulse t16..t17; product=0x0000000F; err=0.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 at done; add_co stays 0 throughout.
- a=0x1234, b=0, then a=0, b=0xABCD -> product=0 both times; in the first run add_b=0 every RUN cycle.
- Start with a=7, b=9; pulse start with a=1, b=1 at t5 and again during DONE -> both ignored; product=63; single done pulse.
- Start a=100, b=200; assert rst at t8 (asynchronous, mid-cycle) -> outputs 0 immediately; no done; next start a=2, b=3 -> product=6.
- Bench adder model forces add_co=1 on the 4th RUN cycle of a=10, b=10 -> err=1 from that edge; remains 1 through the next operations until rst.
